// File: rtl/muldiv_unit.sv
// Multi-cycle multiply/divide unit with HI/LO registers, accumulate, done pulse and divide-by-zero hold.
// The flush input is called disable_en because "disable" is a reserved word in SystemVerilog.
module muldiv_unit #(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             disable_en,
  input  logic             mt_en,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;

  typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_RUN = 1'b1} state_t;

  state_t               state_r, state_nxt_s;
  logic [CNT_W-1:0]     count_r, count_nxt_s;
  logic                 idle_s, mt_req_s, mt_take_s, start_take_s, commit_s;
  logic                 is_div_s, start_op_ok_s;
  logic [2*WIDTH-1:0]   ext_a_s, ext_b_s, prod_s, acc_s;
  logic                 sign_a_s, sign_b_s, div_zero_s;
  logic [WIDTH-1:0]     mag_a_s, mag_b_s, divisor_s, uquot_s, urem_s, quot_s, rem_s;
  logic [WIDTH-1:0]     res_hi_s, res_lo_s;
  logic                 res_wr_s;
  logic [WIDTH-1:0]     shadow_hi_r, shadow_lo_r, hi_r, lo_r;
  logic                 shadow_wr_r, done_r;

  // Acceptance decode: an mt write in IDLE takes priority over a start in the same cycle.
  always_comb begin
    idle_s        = (state_r == ST_IDLE);
    is_div_s      = (op == 3'b010) || (op == 3'b011);
    start_op_ok_s = (op != 3'b100) && (op != 3'b101);
    mt_req_s      = idle_s && mt_en && !disable_en;
    mt_take_s     = mt_req_s && ((op == 3'b100) || (op == 3'b101));
    start_take_s  = idle_s && start && !disable_en && !mt_req_s && start_op_ok_s;
    commit_s      = (state_r == ST_RUN) && (count_r == {CNT_W{1'b0}});
  end

  // Shared multiplier and magnitude divider; op[0] selects unsigned operation.
  always_comb begin
    ext_a_s    = op[0] ? {{WIDTH{1'b0}}, a} : {{WIDTH{a[WIDTH-1]}}, a};
    ext_b_s    = op[0] ? {{WIDTH{1'b0}}, b} : {{WIDTH{b[WIDTH-1]}}, b};
    prod_s     = ext_a_s * ext_b_s;
    acc_s      = {hi_r, lo_r} + prod_s;
    sign_a_s   = ~op[0] & a[WIDTH-1];
    sign_b_s   = ~op[0] & b[WIDTH-1];
    mag_a_s    = sign_a_s ? (~a + {{(WIDTH-1){1'b0}}, 1'b1}) : a;
    mag_b_s    = sign_b_s ? (~b + {{(WIDTH-1){1'b0}}, 1'b1}) : b;
    div_zero_s = (b == {WIDTH{1'b0}});
    divisor_s  = div_zero_s ? {{(WIDTH-1){1'b0}}, 1'b1} : mag_b_s;
    uquot_s    = mag_a_s / divisor_s;
    urem_s     = mag_a_s % divisor_s;
    // MIN / -1 falls out naturally: magnitude 2^(W-1) negated twice wraps back to MIN.
    quot_s     = (sign_a_s ^ sign_b_s) ? (~uquot_s + {{(WIDTH-1){1'b0}}, 1'b1}) : uquot_s;
    rem_s      = sign_a_s ? (~urem_s + {{(WIDTH-1){1'b0}}, 1'b1}) : urem_s;
  end

  // Result selection captured into the shadow registers at launch.
  always_comb begin
    res_hi_s = hi_r;
    res_lo_s = lo_r;
    res_wr_s = 1'b0;
    case (op)
      3'b000, 3'b001: begin
        {res_hi_s, res_lo_s} = prod_s;
        res_wr_s             = 1'b1;
      end
      3'b110, 3'b111: begin
        {res_hi_s, res_lo_s} = acc_s;
        res_wr_s             = 1'b1;
      end
      3'b010, 3'b011: begin
        res_hi_s = rem_s;
        res_lo_s = quot_s;
        res_wr_s = ~div_zero_s;
      end
      default: begin
        res_hi_s = hi_r;
        res_lo_s = lo_r;
        res_wr_s = 1'b0;
      end
    endcase
  end

  // FSM state and cycle counter register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= ST_IDLE;
      count_r <= {CNT_W{1'b0}};
    end else begin
      state_r <= state_nxt_s;
      count_r <= count_nxt_s;
    end
  end

  // Next-state logic: launch from IDLE, count down in RUN, return on the commit edge.
  always_comb begin
    state_nxt_s = state_r;
    count_nxt_s = count_r;
    case (state_r)
      ST_IDLE: begin
        if (start_take_s) begin
          state_nxt_s = ST_RUN;
          count_nxt_s = is_div_s ? CNT_W'(DIV_CYCLES - 1) : CNT_W'(MULT_CYCLES - 1);
        end else begin
          state_nxt_s = ST_IDLE;
          count_nxt_s = count_r;
        end
      end
      ST_RUN: begin
        if (count_r == {CNT_W{1'b0}}) begin
          state_nxt_s = ST_IDLE;
          count_nxt_s = {CNT_W{1'b0}};
        end else begin
          state_nxt_s = ST_RUN;
          count_nxt_s = count_r - {{(CNT_W-1){1'b0}}, 1'b1};
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
        count_nxt_s = {CNT_W{1'b0}};
      end
    endcase
  end

  // Output decode from registered state.
  always_comb begin
    busy = (state_r == ST_RUN);
    done = done_r;
    hi   = hi_r;
    lo   = lo_r;
  end

  // Shadow capture, HI/LO commit or move-to write, and the done pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shadow_hi_r <= {WIDTH{1'b0}};
      shadow_lo_r <= {WIDTH{1'b0}};
      shadow_wr_r <= 1'b0;
      hi_r        <= {WIDTH{1'b0}};
      lo_r        <= {WIDTH{1'b0}};
      done_r      <= 1'b0;
    end else begin
      done_r <= commit_s;
      if (start_take_s) begin
        shadow_hi_r <= res_hi_s;
        shadow_lo_r <= res_lo_s;
        shadow_wr_r <= res_wr_s;
      end
      if (commit_s && shadow_wr_r) begin
        hi_r <= shadow_hi_r;
        lo_r <= shadow_lo_r;
      end else if (mt_take_s) begin
        case (op)
          3'b100:  hi_r <= a;
          3'b101:  lo_r <= a;
          default: hi_r <= hi_r;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Randomised self-checking bench for muldiv_unit: a default instance and a single-cycle-latency instance.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        start = 1'b0;
  logic [2:0]  op = 3'b000;
  logic [31:0] a = 32'h0, b = 32'h0;
  logic        disable_en = 1'b0;
  logic        mt_en = 1'b0;
  logic        busy0, done0, busy1, done1;
  logic [31:0] hi0, lo0, hi1, lo1;

  int n_cmp = 0;
  int n_fail = 0;

  // Reference state per instance: k=0 uses 5/10 cycles, k=1 uses 1/1.
  int          mrem[2];
  logic [31:0] mhi[2], mlo[2], phi[2], plo[2];
  bit          pwr[2], mdone[2];
  int          ncyc_m[2] = '{5, 1};
  int          ncyc_d[2] = '{10, 1};

  always #5 clk = ~clk;

  muldiv_unit #(.WIDTH(32), .MULT_CYCLES(5), .DIV_CYCLES(10)) u_dut0 (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .disable_en(disable_en), .mt_en(mt_en),
    .busy(busy0), .done(done0), .hi(hi0), .lo(lo0)
  );

  muldiv_unit #(.WIDTH(32), .MULT_CYCLES(1), .DIV_CYCLES(1)) u_dut1 (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .disable_en(disable_en), .mt_en(mt_en),
    .busy(busy1), .done(done1), .hi(hi1), .lo(lo1)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Architectural result of an operation from plain integer arithmetic.
  function automatic void compute(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                                  input logic [31:0] hin, input logic [31:0] lin,
                                  output bit wr, output logic [31:0] rh, output logic [31:0] rl);
    logic [63:0] p;
    longint sx, sy;
    wr = 1'b0; rh = hin; rl = lin;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    case (o)
      3'b000, 3'b110, 3'b001, 3'b111: begin
        if (o[0]) p = {32'h0, x} * {32'h0, y};
        else      p = sx * sy;
        if (o[2]) p = p + {hin, lin};
        wr = 1'b1; rh = p[63:32]; rl = p[31:0];
      end
      3'b010: begin
        if (y != 32'h0) begin
          wr = 1'b1;
          if (x == 32'h80000000 && y == 32'hFFFFFFFF) begin
            rl = 32'h80000000; rh = 32'h0;
          end else begin
            rl = 32'(sx / sy); rh = 32'(sx % sy);
          end
        end
      end
      3'b011: begin
        if (y != 32'h0) begin
          wr = 1'b1; rl = x / y; rh = x % y;
        end
      end
      default: wr = 1'b0;
    endcase
  endfunction

  // Cycle-level reference: remaining busy cycles and pending result per instance.
  always @(posedge clk or posedge reset) begin
    for (int k = 0; k < 2; k++) begin
      if (reset) begin
        mrem[k] = 0; mhi[k] = 32'h0; mlo[k] = 32'h0; mdone[k] = 1'b0; pwr[k] = 1'b0;
      end else begin
        mdone[k] = 1'b0;
        if (mrem[k] > 0) begin
          mrem[k]--;
          if (mrem[k] == 0) begin
            mdone[k] = 1'b1;
            if (pwr[k]) begin mhi[k] = phi[k]; mlo[k] = plo[k]; end
          end
        end else if (mt_en && !disable_en) begin
          if (op == 3'b100) mhi[k] = a;
          else if (op == 3'b101) mlo[k] = a;
        end else if (start && !disable_en && op != 3'b100 && op != 3'b101) begin
          compute(op, a, b, mhi[k], mlo[k], pwr[k], phi[k], plo[k]);
          mrem[k] = (op == 3'b010 || op == 3'b011) ? ncyc_d[k] : ncyc_m[k];
        end
      end
    end
  end

  // Every-cycle comparison of both instances against the reference.
  always @(negedge clk) begin
    check("busy0", {63'h0, busy0}, {63'h0, (mrem[0] > 0)});
    check("done0", {63'h0, done0}, {63'h0, mdone[0]});
    check("hilo0", {hi0, lo0}, {mhi[0], mlo[0]});
    check("busy1", {63'h0, busy1}, {63'h0, (mrem[1] > 0)});
    check("done1", {63'h0, done1}, {63'h0, mdone[1]});
    check("hilo1", {hi1, lo1}, {mhi[1], mlo[1]});
  end

  int bc0, dc0, bc1, dc1;

  task automatic run_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    @(negedge clk); #1;
    start = 1'b1; op = o; a = x; b = y;
    bc0 = 0; dc0 = 0; bc1 = 0; dc1 = 0;
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      if (busy0) bc0++;
      if (done0) dc0++;
      if (busy1) bc1++;
      if (done1) dc1++;
      if (i == 0) begin #1; start = 1'b0; end
    end
  endtask

  task automatic mt(input logic [2:0] o, input logic [31:0] x);
    @(negedge clk); #1;
    mt_en = 1'b1; op = o; a = x;
    @(negedge clk); #1;
    mt_en = 1'b0;
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'hFFFFFFFF;
      2: return 32'h80000000;
      3: return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_hilo", {hi0, lo0}, 64'h0);
    check("reset_busy_done", {62'h0, busy0, done0}, 64'h0);
    #1 reset = 1'b0;

    run_op(3'b000, 32'hFFFFFFFD, 32'd7);
    check("mult_busy_cycles", 64'(bc0), 64'd5);
    check("mult_done_pulses", 64'(dc0), 64'd1);
    check("mult_hilo", {hi0, lo0}, 64'hFFFFFFFF_FFFFFFEB);
    check("n1_busy_cycles", 64'(bc1), 64'd1);
    check("n1_mult_hilo", {hi1, lo1}, 64'hFFFFFFFF_FFFFFFEB);

    run_op(3'b011, 32'd100, 32'd7);
    check("divu_busy_cycles", 64'(bc0), 64'd10);
    check("divu_hilo", {hi0, lo0}, {32'd2, 32'd14});

    run_op(3'b010, 32'hFFFFFFF9, 32'd2);
    check("div_neg_hilo", {hi0, lo0}, 64'hFFFFFFFF_FFFFFFFD);

    run_op(3'b010, 32'h80000000, 32'hFFFFFFFF);
    check("div_min_hilo", {hi0, lo0}, 64'h00000000_80000000);

    mt(3'b100, 32'd5);
    mt(3'b101, 32'd9);
    check("mt_hilo", {hi0, lo0}, {32'd5, 32'd9});
    run_op(3'b010, 32'd7, 32'd0);
    check("div0_busy_cycles", 64'(bc0), 64'd10);
    check("div0_done_pulses", 64'(dc0), 64'd1);
    check("div0_hilo_kept", {hi0, lo0}, {32'd5, 32'd9});

    mt(3'b101, 32'hFFFFFFFF);
    mt(3'b100, 32'h0);
    run_op(3'b111, 32'd1, 32'd1);
    check("maddu_hilo", {hi0, lo0}, {32'd1, 32'd0});
    run_op(3'b110, 32'hFFFFFFFF, 32'd1);
    check("madd_hilo", {hi0, lo0}, 64'h00000000_FFFFFFFF);

    // Starts and mt writes during RUN must not disturb the in-flight mult.
    @(negedge clk); #1; start = 1'b1; op = 3'b000; a = 32'd3; b = 32'd4;
    @(negedge clk); #1; op = 3'b011; a = 32'd9; b = 32'd2;
    @(negedge clk); #1; start = 1'b0; mt_en = 1'b1; op = 3'b101; a = 32'hDEADBEEF;
    @(negedge clk); #1; mt_en = 1'b0;
    repeat (10) @(negedge clk);
    check("overlap_hilo", {hi0, lo0}, {32'd0, 32'd12});
    check("overlap_idle", {63'h0, busy0}, 64'h0);

    @(negedge clk); #1; disable_en = 1'b1; start = 1'b1; op = 3'b000; a = 32'd2; b = 32'd2;
    @(negedge clk); #1; start = 1'b0; mt_en = 1'b1; op = 3'b100; a = 32'h1234;
    @(negedge clk);
    check("disable_no_busy", {62'h0, busy0, busy1}, 64'h0);
    #1; mt_en = 1'b0; disable_en = 1'b0;
    @(negedge clk);
    check("disable_hilo_kept", {hi0, lo0}, {32'd0, 32'd12});

    @(negedge clk); #1; start = 1'b1; op = 3'b000; a = 32'd5; b = 32'd5;
    @(negedge clk); #1; start = 1'b0;
    repeat (2) @(negedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    check("midreset_hilo", {hi0, lo0}, 64'h0);
    check("midreset_busy", {63'h0, busy0}, 64'h0);
    #1 reset = 1'b0;
    dc0 = 0;
    repeat (8) begin @(negedge clk); if (done0) dc0++; end
    check("midreset_no_done", 64'(dc0), 64'd0);

    for (int i = 0; i < 3000; i++) begin
      @(negedge clk); #1;
      start      = ($urandom_range(0, 9) < 4);
      mt_en      = ($urandom_range(0, 9) == 0);
      disable_en = ($urandom_range(0, 9) == 0);
      op         = 3'($urandom_range(0, 7));
      a          = pick();
      b          = pick();
      reset      = ($urandom_range(0, 499) == 0);
    end
    @(negedge clk); #1;
    start = 1'b0; mt_en = 1'b0; disable_en = 1'b0; reset = 1'b0;
    repeat (12) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
